// File: rtl/data_memory.sv
// Word-addressed data memory with registered read and a per-word valid bitmap.
// Optional DATA_MEM_UNINIT_FLAG_EN adds uninit_rd, flagging reads of never-written words.
module data_memory #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
`ifdef DATA_MEM_UNINIT_FLAG_EN
    ,
    output logic              uninit_rd
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [DATA_W-1:0] r_read_data;
    logic              w_hit_valid;
    logic [DATA_W-1:0] w_read_next;

    // Same-address write-first: the word being written is the word returned.
    always_comb begin
        w_hit_valid = memWrite | r_valid[data_addr];
        w_read_next = '0;
        if (memWrite) begin
            w_read_next = writeData;
        end else if (r_valid[data_addr]) begin
            w_read_next = r_mem[data_addr];
        end
    end

    // Storage is never cleared; a write while reset is held is dropped.
    always_ff @(posedge clk) begin
        if (memWrite && rst_n) begin
            r_mem[data_addr] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (memWrite) begin
            r_valid[data_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data <= '0;
        end else if (memRead) begin
            r_read_data <= w_read_next;
        end
    end

    assign readData = r_read_data;

`ifdef DATA_MEM_UNINIT_FLAG_EN
    logic r_uninit_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uninit_rd <= 1'b0;
        end else begin
            r_uninit_rd <= memRead & ~w_hit_valid;
        end
    end

    assign uninit_rd = r_uninit_rd;
`else
    logic w_unused_hit;
    assign w_unused_hit = w_hit_valid;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, reset sequences,
// and randomized traffic against an array-based reference model.
module tb_data_memory;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              rst_n;
    logic              memWrite;
    logic              memRead;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
`ifdef DATA_MEM_UNINIT_FLAG_EN
    logic              uninit_rd;
`endif

    data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .data_addr (data_addr),
        .writeData (writeData),
        .readData  (readData)
`ifdef DATA_MEM_UNINIT_FLAG_EN
        ,
        .uninit_rd (uninit_rd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays of word contents and written flags.
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_valid [DEPTH];
    logic [DATA_W-1:0] mdl_rd;
    bit                mdl_un;
    logic [DATA_W-1:0] act_rd;
    logic              act_un;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit                we;
        bit                re;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp_rd;
        bit                exp_un;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        mdl_rd = '0;
        mdl_un = 1'b0;
    endtask

    task automatic sample();
        act_rd = readData;
`ifdef DATA_MEM_UNINIT_FLAG_EN
        act_un = uninit_rd;
`else
        act_un = 1'b0;
`endif
    endtask

    task automatic check_un(input string name, input bit exp);
`ifdef DATA_MEM_UNINIT_FLAG_EN
        check(name, {31'b0, act_un}, {31'b0, exp});
`endif
    endtask

    // One access: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic apply(input bit we, input bit re, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        @(negedge clk);
        memWrite  = we;
        memRead   = re;
        data_addr = a;
        writeData = wd;
        @(posedge clk);
        #1;
        sample();
        if (re) begin
            mdl_un = !(we || m_valid[a]);
            if (we)              mdl_rd = wd;
            else if (m_valid[a]) mdl_rd = m_mem[a];
            else                 mdl_rd = '0;
        end else begin
            mdl_un = 1'b0;
        end
        if (we) begin
            m_mem[a]   = wd;
            m_valid[a] = 1'b1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        memWrite  = 1'b0;
        memRead   = 1'b0;
        data_addr = '0;
        writeData = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        sample();
        check("reset_readData", act_rd, '0);
        check_un("reset_uninit", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{0, 1, 10'd9,    32'h0,        32'h0,        1};
        vecs[1]  = '{1, 0, 10'd9,    32'd24,       32'h0,        0};
        vecs[2]  = '{0, 1, 10'd9,    32'h0,        32'd24,       0};
        vecs[3]  = '{0, 1, 10'd3,    32'h0,        32'h0,        1};
        vecs[4]  = '{0, 1, 10'd9,    32'h0,        32'd24,       0};
        vecs[5]  = '{0, 0, 10'd3,    32'h0,        32'd24,       0};
        vecs[6]  = '{0, 0, 10'd9,    32'h0,        32'd24,       0};
        vecs[7]  = '{1, 1, 10'd5,    32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[8]  = '{0, 1, 10'd5,    32'h0,        32'hDEADBEEF, 0};
        vecs[9]  = '{1, 1, 10'd9,    32'd77,       32'd77,       0};
        vecs[10] = '{0, 1, 10'd9,    32'h0,        32'd77,       0};
        vecs[11] = '{1, 0, 10'd1023, 32'hCAFEF00D, 32'd77,       0};
        vecs[12] = '{1, 0, 10'd0,    32'h11111111, 32'd77,       0};
        vecs[13] = '{0, 1, 10'd1023, 32'h0,        32'hCAFEF00D, 0};
        vecs[14] = '{0, 1, 10'd0,    32'h0,        32'h11111111, 0};
        vecs[15] = '{0, 1, 10'd1022, 32'h0,        32'h0,        1};
        vecs[16] = '{1, 0, 10'd5,    32'hFFFFFFFF, 32'h0,        0};
        vecs[17] = '{0, 1, 10'd5,    32'h0,        32'hFFFFFFFF, 0};

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d_readData", i), act_rd, vecs[i].exp_rd);
            check_un($sformatf("vec%0d_uninit", i), vecs[i].exp_un);
        end

        // Asynchronous reset mid-cycle with a write pending on that edge
        apply(1, 0, 10'd1023, 32'h1234);
        @(negedge clk);
        memWrite  = 1'b1;
        memRead   = 1'b0;
        data_addr = 10'd1023;
        writeData = 32'h9999;
        #2;
        rst_n = 1'b0;
        #1;
        sample();
        check("async_reset_readData", act_rd, '0);
        check_un("async_reset_uninit", 1'b0);
        @(posedge clk);
        @(negedge clk);
        memWrite = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        apply(0, 1, 10'd1023, 32'h0);
        check("post_reset_rd_1023", act_rd, '0);
        check_un("post_reset_un_1023", 1'b1);
        apply(0, 1, 10'd9, 32'h0);
        check("post_reset_rd_9", act_rd, '0);
        apply(1, 0, 10'd1023, 32'h55);
        apply(0, 1, 10'd1023, 32'h0);
        check("rewrite_rd_1023", act_rd, 32'h55);
        check_un("rewrite_un_1023", 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bit                we;
            bit                re;
            logic [ADDR_W-1:0] a;
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(0, DEPTH - 1));
            else                           a = ADDR_W'($urandom_range(0, 15));
            apply(we, re, a, $urandom);
            check($sformatf("rand%0d_readData", i), act_rd, mdl_rd);
            check_un($sformatf("rand%0d_uninit", i), mdl_un);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
